// File: rtl/clock_domain_sequencer.sv
// ---------------------------------------------------------------------------
// clock_domain_sequencer
//
// Purpose:
//   Sits behind the MMCM / clock-wizard lock output. It synchronises the lock,
//   waits for it to be stable, and then releases one reset per clock domain
//   in ascending channel order with a fixed stagger. Each channel also gets a
//   runtime-programmable clock-enable pulse, so slow logic can run on the fast
//   clock. A loss of lock after release has begun puts every domain back into
//   reset and is counted in a saturating counter.
//
// Ports:
//   iclk_100MHz    in   1           system clock, all logic on the rising edge
//   irst           in   1           synchronous active-high reset
//   iclk_locked    in   1           MMCM lock, asynchronous to iclk_100MHz
//   idiv           in   N_CH*DIV_W  divisor per channel, ch k = idiv[k*DIV_W +: DIV_W]
//   orst           out  N_CH        active-high reset per channel domain
//   oce            out  N_CH        one-cycle clock-enable pulse per channel
//   oready         out  1           all channels released and lock held
//   olock_loss_cnt out  LOSS_CNT_W  saturating count of lock losses after release began
//   ostate         out  2           FSM state: 0 WAIT_LOCK, 1 STABLE, 2 RELEASE, 3 RUN
// ---------------------------------------------------------------------------
module clock_domain_sequencer #(
    parameter int N_CH            = 2,
    parameter int DIV_W           = 16,
    parameter int LOCK_STABLE_CYC = 1024,
    parameter int RST_STAGGER     = 16,
    parameter int LOSS_CNT_W      = 8
) (
    input  logic                    iclk_100MHz,
    input  logic                    irst,
    input  logic                    iclk_locked,
    input  logic [N_CH*DIV_W-1:0]   idiv,
    output logic [N_CH-1:0]         orst,
    output logic [N_CH-1:0]         oce,
    output logic                    oready,
    output logic [LOSS_CNT_W-1:0]   olock_loss_cnt,
    output logic [1:0]              ostate
);

    localparam int STAB_W = (LOCK_STABLE_CYC > 1) ? $clog2(LOCK_STABLE_CYC) : 1;
    localparam int STAG_W = (RST_STAGGER > 1) ? $clog2(RST_STAGGER) : 1;
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [STAB_W-1:0]     STAB_LAST = STAB_W'(LOCK_STABLE_CYC - 1);
    localparam logic [STAG_W-1:0]     STAG_LAST = STAG_W'(RST_STAGGER - 1);
    localparam logic [CH_W-1:0]       CH_LAST   = CH_W'(N_CH - 1);
    localparam logic [LOSS_CNT_W-1:0] LOSS_MAX  = '1;

    localparam logic [1:0] S_WAIT_LOCK = 2'd0;
    localparam logic [1:0] S_STABLE    = 2'd1;
    localparam logic [1:0] S_RELEASE   = 2'd2;
    localparam logic [1:0] S_RUN       = 2'd3;

    // Two-flop lock synchroniser; only locked_s is used by the sequencer.
    logic sync1_q, sync2_q;
    logic locked_s;
    assign locked_s = sync2_q;

    logic [1:0]            state_q, state_d;
    logic [STAB_W-1:0]     stab_q,  stab_d;
    logic [STAG_W-1:0]     stag_q,  stag_d;
    logic [CH_W-1:0]       ch_q,    ch_d;     // next channel to be released
    logic [N_CH-1:0]       rst_q,   rst_d;
    logic                  ready_q, ready_d;
    logic [LOSS_CNT_W-1:0] loss_q,  loss_d;
    logic                  loss_evt;

    // A loss only counts once release has started; a dropout while still
    // qualifying simply restarts the qualification.
    assign loss_evt = !locked_s && (state_q == S_RELEASE || state_q == S_RUN);

    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        stag_d  = stag_q;
        ch_d    = ch_q;
        rst_d   = rst_q;
        ready_d = ready_q;
        loss_d  = loss_q;

        if (loss_evt) begin
            state_d = S_WAIT_LOCK;
            rst_d   = '1;
            ready_d = 1'b0;
            stab_d  = '0;
            stag_d  = '0;
            if (loss_q != LOSS_MAX) begin
                loss_d = loss_q + 1'b1;
            end
        end else begin
            case (state_q)
                S_WAIT_LOCK: begin
                    rst_d   = '1;
                    ready_d = 1'b0;
                    stab_d  = '0;
                    if (locked_s) begin
                        state_d = S_STABLE;
                    end
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        state_d = S_WAIT_LOCK;
                        stab_d  = '0;
                    end else if (stab_q == STAB_LAST) begin
                        // Channel 0 is released on the edge entering RELEASE.
                        state_d  = S_RELEASE;
                        stab_d   = '0;
                        stag_d   = '0;
                        ch_d     = CH_W'(1);
                        rst_d[0] = 1'b0;
                        if (N_CH == 1) begin
                            state_d = S_RUN;
                            ready_d = 1'b1;
                        end
                    end else begin
                        stab_d = stab_q + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (stag_q == STAG_LAST) begin
                        stag_d      = '0;
                        rst_d[ch_q] = 1'b0;
                        if (ch_q == CH_LAST) begin
                            state_d = S_RUN;
                            ready_d = 1'b1;
                        end else begin
                            ch_d = ch_q + 1'b1;
                        end
                    end else begin
                        stag_d = stag_q + 1'b1;
                    end
                end
                S_RUN: begin
                    state_d = S_RUN;
                end
                default: begin
                    state_d = S_WAIT_LOCK;
                    rst_d   = '1;
                    ready_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge iclk_100MHz) begin
        if (irst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= S_WAIT_LOCK;
            stab_q  <= '0;
            stag_q  <= '0;
            ch_q    <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
            loss_q  <= '0;
        end else begin
            sync1_q <= iclk_locked;
            sync2_q <= sync1_q;
            state_q <= state_d;
            stab_q  <= stab_d;
            stag_q  <= stag_d;
            ch_q    <= ch_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            loss_q  <= loss_d;
        end
    end

    // Per-channel clock-enable divider. It looks at rst_d so that oce is
    // registered yet already valid in the first cycle a channel is out of
    // reset (needed for D<=1). The divisor is latched only at release and at
    // the end of each period, so a mid-period change never distorts a period.
    for (genvar k = 0; k < N_CH; k++) begin : g_ce
        logic [DIV_W-1:0] cnt_q;
        logic [DIV_W-1:0] div_q;
        logic             oce_q;
        logic [DIV_W-1:0] new_div;
        logic [DIV_W-1:0] cnt_inc;
        logic [DIV_W-1:0] div_m1;
        logic             wrap;

        assign new_div = idiv[k*DIV_W +: DIV_W];
        assign cnt_inc = cnt_q + 1'b1;
        assign div_m1  = div_q - 1'b1;
        assign wrap    = (div_q <= DIV_W'(1)) || (cnt_q == div_m1);

        always_ff @(posedge iclk_100MHz) begin
            if (irst) begin
                cnt_q <= '0;
                div_q <= '0;
                oce_q <= 1'b0;
            end else if (rst_d[k]) begin
                cnt_q <= '0;
                oce_q <= 1'b0;
            end else if (rst_q[k] || wrap) begin
                // Start of a new period: first released cycle or wrap.
                div_q <= new_div;
                cnt_q <= '0;
                oce_q <= (new_div <= DIV_W'(1));
            end else begin
                cnt_q <= cnt_inc;
                oce_q <= (cnt_inc == div_m1);
            end
        end

        assign oce[k] = oce_q;
    end

    assign orst           = rst_q;
    assign oready         = ready_q;
    assign olock_loss_cnt = loss_q;
    assign ostate         = state_q;

endmodule

// File: tb/tb_clock_domain_sequencer.sv
// ---------------------------------------------------------------------------
// tb_clock_domain_sequencer
//
// Directed bench: a 2-channel instance (LOCK_STABLE_CYC=8, RST_STAGGER=4,
// LOSS_CNT_W=2) plus a 1-channel instance sharing the lock input. Inputs are
// changed 1 time unit after a rising edge and outputs are checked at that
// same point, so "edge n" below means "just after the n-th rising edge
// counted from the edge where the stimulus changed".
// ---------------------------------------------------------------------------
module tb_clock_domain_sequencer;

    localparam int N_CH = 2;
    localparam int DIV_W = 8;

    logic              clk;
    logic              irst;
    logic              locked;
    logic [N_CH*DIV_W-1:0] idiv;
    logic [N_CH-1:0]   orst;
    logic [N_CH-1:0]   oce;
    logic              oready;
    logic [1:0]        loss_cnt;
    logic [1:0]        ostate;

    logic [DIV_W-1:0]  idiv1;
    logic [0:0]        orst1;
    logic [0:0]        oce1;
    logic              oready1;
    logic [1:0]        loss_cnt1;
    logic [1:0]        ostate1;

    int n_cmp = 0;
    int n_err = 0;
    logic [1:0] exp_q[$];

    clock_domain_sequencer #(
        .N_CH(2), .DIV_W(DIV_W), .LOCK_STABLE_CYC(8), .RST_STAGGER(4), .LOSS_CNT_W(2)
    ) dut (
        .iclk_100MHz(clk), .irst(irst), .iclk_locked(locked), .idiv(idiv),
        .orst(orst), .oce(oce), .oready(oready),
        .olock_loss_cnt(loss_cnt), .ostate(ostate)
    );

    clock_domain_sequencer #(
        .N_CH(1), .DIV_W(DIV_W), .LOCK_STABLE_CYC(8), .RST_STAGGER(4), .LOSS_CNT_W(2)
    ) dut1 (
        .iclk_100MHz(clk), .irst(irst), .iclk_locked(locked), .idiv(idiv1),
        .orst(orst1), .oce(oce1), .oready(oready1),
        .olock_loss_cnt(loss_cnt1), .ostate(ostate1)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Driver helper
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Checker
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        irst   = 1'b1;
        locked = 1'b0;
        idiv   = {8'd5, 8'd1};
        idiv1  = 8'd1;
        tick(3);

        // Reset values
        check("rst_orst",   orst,     2'b11);
        check("rst_oce",    oce,      2'b00);
        check("rst_ready",  oready,   1'b0);
        check("rst_loss",   loss_cnt, 2'd0);
        check("rst_state",  ostate,   2'd0);
        irst = 1'b0;
        tick(2);
        check("idle_state", ostate,   2'd0);

        // Lock up: lock rises at edge 0
        locked = 1'b1;
        tick(2);
        check("t1_e2_state", ostate, 2'd0);
        tick(1);
        check("t1_e3_state", ostate, 2'd1);
        tick(7);
        check("t1_e10_state", ostate, 2'd1);
        check("t1_e10_orst",  orst,   2'b11);
        tick(1);
        check("t1_e11_orst",  orst,   2'b10);
        check("t1_e11_state", ostate, 2'd2);
        check("t1_e11_oce",   oce,    2'b01);
        check("t1_e11_ready", oready, 1'b0);
        check("n1_e11_orst",  orst1,  1'b0);
        check("n1_e11_ready", oready1, 1'b1);
        check("n1_e11_state", ostate1, 2'd3);
        check("n1_e11_oce",   oce1,   1'b1);
        tick(3);
        check("t1_e14_orst",  orst,   2'b10);
        check("t1_e14_state", ostate, 2'd2);
        tick(1);
        check("t1_e15_orst",  orst,   2'b00);
        check("t1_e15_ready", oready, 1'b1);
        check("t1_e15_state", ostate, 2'd3);
        check("t1_e15_oce",   oce,    2'b01);

        // Divisors ch0=1, ch1=5, then ch1 5->3 issued mid-period at edge 26.
        // ch1 pulses: 19, 24, 29 (old period finishes), then 32, 35, 38.
        for (int e = 16; e <= 38; e++) begin
            exp_q.push_back((e == 19 || e == 24 || e == 29 ||
                             e == 32 || e == 35 || e == 38) ? 2'b11 : 2'b01);
        end
        for (int e = 16; e <= 38; e++) begin
            logic [1:0] exp_v;
            tick(1);
            exp_v = exp_q.pop_front();
            check($sformatf("ce_e%0d", e), oce, exp_v);
            if (e == 26) idiv[15:8] = 8'd3;
        end

        // Lock loss in RUN
        locked = 1'b0;
        tick(2);
        check("t3_e2_state", ostate, 2'd3);
        tick(1);
        check("t3_e3_orst",  orst,     2'b11);
        check("t3_e3_oce",   oce,      2'b00);
        check("t3_e3_ready", oready,   1'b0);
        check("t3_e3_state", ostate,   2'd0);
        check("t3_e3_loss",  loss_cnt, 2'd1);
        check("n1_loss",     loss_cnt1, 2'd1);

        // Relock with a 3-cycle glitch while STABLE; count must restart
        locked = 1'b1;
        tick(5);
        locked = 1'b0;
        tick(3);
        locked = 1'b1;
        check("t2_e8_state",  ostate, 2'd0);
        tick(2);
        check("t2_e10_state", ostate, 2'd0);
        tick(1);
        check("t2_e11_state", ostate, 2'd1);
        check("t2_e11_loss",  loss_cnt, 2'd1);
        tick(7);
        check("t2_e18_state", ostate, 2'd1);
        check("t2_e18_orst",  orst,   2'b11);
        tick(1);
        check("t2_e19_state", ostate, 2'd2);
        check("t2_e19_orst",  orst,   2'b10);
        tick(4);
        check("t2_e23_orst",  orst,   2'b00);
        check("t2_e23_ready", oready, 1'b1);
        check("t2_e23_loss",  loss_cnt, 2'd1);

        // Four more losses: counter saturates at 3
        for (int i = 0; i < 4; i++) begin
            locked = 1'b1;
            tick(12);
            locked = 1'b0;
            tick(3);
            check($sformatf("sat_loss_%0d", i), loss_cnt, (i == 0) ? 2'd2 : 2'd3);
            check($sformatf("sat_state_%0d", i), ostate, 2'd0);
        end
        check("sat_orst", orst, 2'b11);

        // Reset together with a lock loss during RELEASE: reset wins
        locked = 1'b1;
        tick(12);
        check("t6_e12_state", ostate, 2'd2);
        locked = 1'b0;
        tick(2);
        irst = 1'b1;
        tick(1);
        check("t6_orst",  orst,     2'b11);
        check("t6_oce",   oce,      2'b00);
        check("t6_ready", oready,   1'b0);
        check("t6_state", ostate,   2'd0);
        check("t6_loss",  loss_cnt, 2'd0);
        irst = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
